// File: rtl/m68k_target_if.sv
// m68k_target_if: 68000-side strobes/address and local-memory handshake used by
// m68k_target. The open-drain DTACK/BERR pins are plain ports on the module.
interface m68k_target_if;
    logic        AS;
    logic        UDS;
    logic        LDS;
    logic        RW;
    logic [23:1] A;
    logic        CONFIGURED;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [23:1] MEM_ADDR;
    logic [1:0]  MEM_BE;
    logic        MEM_ACK;
    logic        DOE;
    logic        HIT;

    // Responder side: the target block itself
    modport slave (
        input  AS, UDS, LDS, RW, A, CONFIGURED, MEM_ACK,
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE, DOE, HIT
    );

    // Bus master / memory controller side
    modport master (
        output AS, UDS, LDS, RW, A, CONFIGURED, MEM_ACK,
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE, DOE, HIT
    );
endinterface

// File: rtl/m68k_target.sv
// m68k_target: responder-side 68000 bus interface. Synchronises AS/UDS/LDS into
// the CLKCPU domain, decodes the A[23:21] window, runs a level request / pulse
// acknowledge handshake with local memory and answers with open-drain DTACK.
// Optional feature: define BUS_TARGET_TIMEOUT_EN to add an 8-bit timeout that
// answers with BERR instead of DTACK after TIMEOUT cycles.
module m68k_target #(
    parameter logic [2:0] BASE    = 3'b001,
    parameter int         TIMEOUT = 64
) (
    input  logic         CLKCPU,
    input  logic         RESET,
    m68k_target_if.slave bus,
    output wire          DTACK,
    output wire          BERR
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MISS,
        ST_STROBE,
        ST_WAIT,
        ST_ACK,
        ST_ABORT,
        ST_ERR
    } state_t;

    state_t      state_reg, state_next;

    logic        as_meta_reg, as_s_reg, as_p_reg;
    logic        uds_meta_reg, uds_s_reg;
    logic        lds_meta_reg, lds_s_reg;

    logic [23:1] mem_addr_reg, mem_addr_next;
    logic        mem_we_reg, mem_we_next;
    logic [1:0]  mem_be_reg, mem_be_next;
    logic        aborted_reg, aborted_next;

    logic        mem_req_reg, dtack_reg, doe_reg, hit_reg;

    logic        as_fall, window_hit, strobe_seen, tmo_expire;

`ifdef BUS_TARGET_TIMEOUT_EN
    logic [7:0]  tmo_cnt_reg, tmo_cnt_next;
    logic        berr_reg;

    // Expire decision is taken one cycle early so BERR lands exactly TIMEOUT
    // edges after STROBE entry.
    assign tmo_expire = (tmo_cnt_reg == 8'(TIMEOUT - 1));
    assign BERR       = berr_reg ? 1'b0 : 1'bz;
`else
    // No counter in this build: the timeout can never fire and BERR floats.
    assign tmo_expire = 1'b0 && (TIMEOUT > 0);
    assign BERR       = 1'bz;
`endif

    assign DTACK        = dtack_reg ? 1'b0 : 1'bz;

    assign as_fall      = !as_s_reg && as_p_reg;
    // A is sampled directly: the master set it up before AS, and AS has already
    // been through two flops by the time this is used.
    assign window_hit   = bus.CONFIGURED && (bus.A[23:21] == BASE);
    assign strobe_seen  = !uds_s_reg || !lds_s_reg;

    assign bus.MEM_REQ  = mem_req_reg;
    assign bus.MEM_WE   = mem_we_reg;
    assign bus.MEM_ADDR = mem_addr_reg;
    assign bus.MEM_BE   = mem_be_reg;
    assign bus.DOE      = doe_reg;
    assign bus.HIT      = hit_reg;

    // Two-flop synchronisers plus the AS edge-detect stage. AS_s/AS_p reset low
    // so a strobe held across reset is not mistaken for a new falling edge.
    always_ff @(posedge CLKCPU) begin
        if (!RESET) begin
            as_meta_reg  <= 1'b0;
            as_s_reg     <= 1'b0;
            as_p_reg     <= 1'b0;
            uds_meta_reg <= 1'b1;
            uds_s_reg    <= 1'b1;
            lds_meta_reg <= 1'b1;
            lds_s_reg    <= 1'b1;
        end else begin
            as_meta_reg  <= bus.AS;
            as_s_reg     <= as_meta_reg;
            as_p_reg     <= as_s_reg;
            uds_meta_reg <= bus.UDS;
            uds_s_reg    <= uds_meta_reg;
            lds_meta_reg <= bus.LDS;
            lds_s_reg    <= lds_meta_reg;
        end
    end

    // State register and latched transaction fields
    always_ff @(posedge CLKCPU) begin
        if (!RESET) begin
            state_reg    <= ST_IDLE;
            mem_addr_reg <= '0;
            mem_we_reg   <= 1'b0;
            mem_be_reg   <= 2'b00;
            aborted_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            mem_addr_reg <= mem_addr_next;
            mem_we_reg   <= mem_we_next;
            mem_be_reg   <= mem_be_next;
            aborted_reg  <= aborted_next;
        end
    end

    // Next-state decode and field latching
    always_comb begin
        state_next    = state_reg;
        mem_addr_next = mem_addr_reg;
        mem_we_next   = mem_we_reg;
        mem_be_next   = mem_be_reg;
        aborted_next  = aborted_reg;
`ifdef BUS_TARGET_TIMEOUT_EN
        tmo_cnt_next  = tmo_cnt_reg;
        if (state_reg == ST_STROBE || state_reg == ST_WAIT) begin
            tmo_cnt_next = tmo_cnt_reg + 8'd1;
        end
`endif
        case (state_reg)
            ST_IDLE: begin
                if (as_fall) begin
                    if (window_hit) begin
                        mem_addr_next = bus.A;
                        mem_we_next   = !bus.RW;
                        aborted_next  = 1'b0;
`ifdef BUS_TARGET_TIMEOUT_EN
                        tmo_cnt_next  = 8'd0;
`endif
                        state_next    = ST_STROBE;
                    end else begin
                        state_next    = ST_MISS;
                    end
                end
            end
            ST_MISS: begin
                if (as_s_reg) state_next = ST_IDLE;
            end
            ST_STROBE: begin
                if (as_s_reg) begin
                    state_next = ST_IDLE;
                end else if (strobe_seen) begin
                    mem_be_next = {!uds_s_reg, !lds_s_reg};
                    state_next  = ST_WAIT;
                end else if (tmo_expire) begin
                    state_next  = ST_ERR;
                end
            end
            ST_WAIT: begin
                // Once the master has let go of AS the request still has to be
                // completed, but nobody is left to see DTACK or BERR.
                if (as_s_reg) aborted_next = 1'b1;
                if (bus.MEM_ACK) begin
                    state_next = (aborted_reg || as_s_reg) ? ST_ABORT : ST_ACK;
                end else if (tmo_expire) begin
                    state_next = (aborted_reg || as_s_reg) ? ST_ABORT : ST_ERR;
                end
            end
            ST_ACK: begin
                if (as_s_reg) state_next = ST_IDLE;
            end
            ST_ABORT: begin
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                if (as_s_reg) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Bus-facing outputs loaded from the next-state decode so each pin comes
    // straight from a flop and cannot glitch.
    always_ff @(posedge CLKCPU) begin
        if (!RESET) begin
            mem_req_reg <= 1'b0;
            dtack_reg   <= 1'b0;
            doe_reg     <= 1'b0;
            hit_reg     <= 1'b0;
        end else begin
            mem_req_reg <= (state_next == ST_WAIT);
            dtack_reg   <= (state_next == ST_ACK);
            // Read data is not driven once the cycle has been abandoned.
            doe_reg     <= !mem_we_next &&
                           ((state_next == ST_WAIT && !aborted_next) ||
                            state_next == ST_ACK);
            hit_reg     <= (state_next == ST_STROBE) || (state_next == ST_WAIT) ||
                           (state_next == ST_ACK)    || (state_next == ST_ERR);
        end
    end

`ifdef BUS_TARGET_TIMEOUT_EN
    // Timeout counter and BERR driver
    always_ff @(posedge CLKCPU) begin
        if (!RESET) begin
            tmo_cnt_reg <= 8'd0;
            berr_reg    <= 1'b0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_next;
            berr_reg    <= (state_next == ST_ERR);
        end
    end
`endif

endmodule
